// File: rtl/data_registers_inv_unit_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 decryption data-register unit.
package data_registers_inv_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARK,
      ISR,
      SUB,
      IMC,
      OUT
   } state_t;

   localparam int BEATS   = 8;
   localparam int IMC_CYC = 4;
   localparam logic [7:0] GF_POLY = 8'h1B;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/data_registers_inv_unit_inv_mix_column.sv
// Combinational InvMixColumns on one 4-byte column {a0,a1,a2,a3} (matrix 0e,0b,0d,09).
module inv_mix_column_unit
   import data_registers_inv_unit_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] res
);

   // k selects which of b, 2b, 4b, 8b are summed, so k=4'he gives 0e*b.
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col[31:24];
   assign a1 = col[23:16];
   assign a2 = col[15:8];
   assign a3 = col[7:0];

   assign res[31:24] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
   assign res[23:16] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
   assign res[15:8]  = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
   assign res[7:0]   = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);

endmodule

// File: rtl/data_registers_inv_unit.sv
// AES-128 decryption state register, 2-byte serial datapath with internal phase FSM.
// Build option INVREG_ZEROIZE_EN: unload shifts in zeros and IDLE keeps the state cleared.
module data_registers_inv_unit
   import data_registers_inv_unit_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic [15:0] stateout,
   output logic        sb_bypass,
   output logic [3:0]  key_idx,
   input  logic [15:0] sbox_in,
   output logic [15:0] plain,
   output logic        plain_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
   localparam logic [2:0] LAST_IMC  = 3'(IMC_CYC - 1);
   localparam logic [3:0] NR_4      = 4'(NR);

   state_t      state, state_nxt;
   logic [7:0]  s [16];
   logic [2:0]  beat, beat_nxt;
   logic [3:0]  rnd, rnd_nxt;
   logic        shift_en;
   logic [15:0] shift_val;
   logic [31:0] imc_res;

   inv_mix_column_unit u_imc (
      .col ({s[0], s[1], s[2], s[3]}),
      .res (imc_res)
   );

   assign stateout = {s[0], s[1]};
   assign plain    = {s[0], s[1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         beat  <= '0;
         rnd   <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
         rnd   <= rnd_nxt;
      end
   end

   // rnd counts rounds 1..NR; key_idx in ISR/IMC repeats the index of the preceding pass.
   always_comb begin
      state_nxt   = state;
      beat_nxt    = beat;
      rnd_nxt     = rnd;
      busy        = (state != IDLE);
      done        = 1'b0;
      plain_valid = 1'b0;
      sb_bypass   = 1'b0;
      key_idx     = '0;
      shift_en    = 1'b0;
      shift_val   = sbox_in;
      case (state)
         IDLE: begin
            beat_nxt = '0;
            rnd_nxt  = '0;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            shift_en  = din_valid;
            shift_val = din;
            if (din_valid) begin
               beat_nxt = beat + 3'd1;
               if (beat == LAST_BEAT) state_nxt = ARK;
            end
         end
         ARK: begin
            shift_en  = 1'b1;
            sb_bypass = 1'b1;
            key_idx   = NR_4;
            beat_nxt  = beat + 3'd1;
            if (beat == LAST_BEAT) begin
               state_nxt = ISR;
               rnd_nxt   = 4'd1;
            end
         end
         ISR: begin
            key_idx   = NR_4 - rnd + 4'd1;
            state_nxt = SUB;
         end
         SUB: begin
            shift_en = 1'b1;
            key_idx  = NR_4 - rnd;
            beat_nxt = beat + 3'd1;
            if (beat == LAST_BEAT) state_nxt = (rnd == NR_4) ? OUT : IMC;
         end
         IMC: begin
            key_idx  = NR_4 - rnd;
            beat_nxt = beat + 3'd1;
            if (beat == LAST_IMC) begin
               beat_nxt  = '0;
               rnd_nxt   = rnd + 4'd1;
               state_nxt = ISR;
            end
         end
         OUT: begin
            plain_valid = 1'b1;
            shift_en    = out_ready;
`ifdef INVREG_ZEROIZE_EN
            shift_val   = '0;
`else
            shift_val   = {s[0], s[1]};
`endif
            if (out_ready) begin
               beat_nxt = beat + 3'd1;
               if (beat == LAST_BEAT) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State bytes are column-major: s[4*c + r] holds row r of column c.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) s[i] <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < 14; i++) s[i] <= s[i+2];
         s[14] <= shift_val[15:8];
         s[15] <= shift_val[7:0];
      end else if (state == ISR) begin
         s[1]  <= s[13];
         s[5]  <= s[1];
         s[9]  <= s[5];
         s[13] <= s[9];
         s[2]  <= s[10];
         s[6]  <= s[14];
         s[10] <= s[2];
         s[14] <= s[6];
         s[3]  <= s[7];
         s[7]  <= s[11];
         s[11] <= s[15];
         s[15] <= s[3];
      end else if (state == IMC) begin
         for (int i = 0; i < 12; i++) s[i] <= s[i+4];
         s[12] <= imc_res[31:24];
         s[13] <= imc_res[23:16];
         s[14] <= imc_res[15:8];
         s[15] <= imc_res[7:0];
`ifdef INVREG_ZEROIZE_EN
      end else if (state == IDLE) begin
         for (int i = 0; i < 16; i++) s[i] <= '0;
`endif
      end
   end

endmodule

// File: tb/tb_data_registers_inv_unit.sv
// Bench for data_registers_inv_unit: FIPS-197 C.1 decryption with a modelled InvSBox/key path,
// stall, abort, held-start and single-round ShiftRows probes, plus InvMixColumns column vectors.
module tb_data_registers_inv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, din_valid, out_ready;
   logic [15:0] din, sbox_in;
   logic [15:0] stateout, plain;
   logic        sb_bypass, plain_valid, busy, done;
   logic [3:0]  key_idx;

   logic        start_p, din_valid_p, out_ready_p;
   logic [15:0] din_p, sbox_in_p;
   logic [15:0] stateout_p, plain_p;
   logic        sb_bypass_p, plain_valid_p, busy_p, done_p;
   logic [3:0]  key_idx_p;

   logic [31:0] imc_col, imc_res;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]   sb     [256];
   logic [7:0]   inv_sb [256];
   logic [31:0]  w      [44];
   logic [127:0] ct_v;
   logic [127:0] pt_v;
   logic [127:0] key_v;

   typedef struct {
      logic [31:0] col;
      logic [31:0] exp;
   } imc_vec_t;

   typedef struct {
      int         cyc;
      logic [6:0] exp;   // {busy, sb_bypass, key_idx, plain_valid}
   } probe_t;

   imc_vec_t imc_tab [4];
   probe_t   probes  [12];

   data_registers_inv_unit #(.NR(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .din         (din),
      .din_valid   (din_valid),
      .stateout    (stateout),
      .sb_bypass   (sb_bypass),
      .key_idx     (key_idx),
      .sbox_in     (sbox_in),
      .plain       (plain),
      .plain_valid (plain_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   data_registers_inv_unit #(.NR(1)) dut_p (
      .clk         (clk),
      .rst         (rst),
      .start       (start_p),
      .din         (din_p),
      .din_valid   (din_valid_p),
      .stateout    (stateout_p),
      .sb_bypass   (sb_bypass_p),
      .key_idx     (key_idx_p),
      .sbox_in     (sbox_in_p),
      .plain       (plain_p),
      .plain_valid (plain_valid_p),
      .out_ready   (out_ready_p),
      .busy        (busy_p),
      .done        (done_p)
   );

   inv_mix_column_unit u_imc_probe (
      .col (imc_col),
      .res (imc_res)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] rkey(input int k, input int j);
      logic [31:0] wd;
      wd = w[4*k + j/4];
      return wd[31 - 8*(j%4) -: 8];
   endfunction

   // Model of the external InvSBox / round-key XOR path.
   function automatic logic [15:0] ext_path(input logic [15:0] so, input logic byp,
                                            input logic [3:0] ki, input int j);
      logic [7:0] b0, b1;
      int k;
      k  = (ki > 4'd10) ? 0 : int'(ki);
      b0 = byp ? so[15:8] : inv_sb[so[15:8]];
      b1 = byp ? so[7:0]  : inv_sb[so[7:0]];
      return {b0 ^ rkey(k, j), b1 ^ rkey(k, j + 1)};
   endfunction

   task automatic build_tables();
      logic [7:0]  inv, r, rcon;
      logic [31:0] t;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r = inv ^ 8'h63;
         for (int n = 1; n <= 4; n++) r = r ^ rotl(inv, n);
         sb[x] = r;
      end
      for (int x = 0; x < 256; x++) inv_sb[sb[x]] = 8'(x);
      for (int i = 0; i < 4; i++) w[i] = key_v[127 - 32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t    = {t[23:0], t[31:24]};
            t    = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Runs one C.1 block starting at cycle 0 (start sampled at the end of cycle 0).
   task automatic run_block(input string tag, input int ld_stalls, input int out_stalls,
                            input bit hold_start, input int abort_at, input bit probe,
                            input int exp_first, input int exp_done);
      int cyc, nin, nout, ark0, ndone, first_cyc, done_cyc, u, k, j;
      logic [127:0] pt;
      logic [15:0]  first_beat;
      cyc = 0; nin = 0; nout = 0; ark0 = -1; ndone = 0;
      first_cyc = -1; done_cyc = -1; pt = '0; first_beat = '0;
      start = 1'b1;
      while (cyc < 400) begin
         if (cyc > 0 && !hold_start) start = 1'b0;
         if (cyc >= 1 && nin < 8) begin
            if (ld_stalls > 0 && ($urandom_range(0, 1) == 1 || nin == 7)) begin
               din_valid = 1'b0;
               din       = 16'($urandom);
               ld_stalls--;
            end else begin
               din_valid = 1'b1;
               din       = ct_v[127 - 16*nin -: 16];
               nin++;
               if (nin == 8) ark0 = cyc + 1;
            end
         end else begin
            din_valid = 1'($urandom_range(0, 1));
            din       = 16'($urandom);
         end
         j = 0;
         if (ark0 >= 0 && cyc >= ark0) begin
            u = cyc - ark0;
            if (u < 8) j = 2*u;
            else begin
               k = (u - 8) % 13;
               if (k >= 1 && k <= 8) j = 2*(k - 1);
            end
         end
         sbox_in = ext_path(stateout, sb_bypass, key_idx, j);
         if (plain_valid && out_stalls > 0) begin
            out_ready = 1'b0;
            out_stalls--;
         end else begin
            out_ready = 1'b1;
         end
         if (plain_valid && first_cyc < 0) begin
            first_cyc  = cyc;
            first_beat = plain;
         end
         if (plain_valid && out_ready) begin
            pt = {pt[111:0], plain};
            nout++;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (probe)
            foreach (probes[p])
               if (probes[p].cyc == cyc)
                  check($sformatf("%s probe c%0d", tag, cyc),
                        {busy, sb_bypass, key_idx, plain_valid}, probes[p].exp);
         if (cyc == abort_at) begin
            check({tag, " pre-abort sub5"}, {busy, sb_bypass, key_idx}, {1'b1, 1'b0, 4'd5});
            rst = 1'b1;
            @(posedge clk); #1;
            check({tag, " post-rst outputs"},
                  {busy, done, plain_valid, sb_bypass, key_idx, stateout, plain}, '0);
            rst   = 1'b0;
            start = 1'b0;
            return;
         end
         if (nout == 8) break;
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " beats"}, nout, 8);
      check({tag, " plaintext"}, pt, pt_v);
      check({tag, " first beat"}, first_beat, 16'h0011);
      check({tag, " first cycle"}, first_cyc, exp_first);
      check({tag, " done cycle"}, done_cyc, exp_done);
      check({tag, " done count"}, ndone, 1);
      @(posedge clk); #1;
`ifdef INVREG_ZEROIZE_EN
      check({tag, " idle busy/state"}, {busy, stateout}, {1'b0, 16'h0000});
`else
      check({tag, " idle busy/state"}, {busy, stateout}, {1'b0, 16'h0011});
`endif
   endtask

   // NR=1 instance with an identity external path isolates a single InvShiftRows.
   task automatic run_isr_probe();
      int cyc, nin, nout;
      logic [127:0] pt;
      cyc = 0; nin = 0; nout = 0; pt = '0;
      start_p = 1'b1;
      while (cyc < 100 && nout < 8) begin
         if (cyc > 0) start_p = 1'b0;
         din_valid_p = (cyc >= 1 && nin < 8);
         din_p       = {8'(2*nin), 8'(2*nin + 1)};
         if (din_valid_p) nin++;
         sbox_in_p   = stateout_p;
         out_ready_p = 1'b1;
         if (plain_valid_p) begin
            pt = {pt[111:0], plain_p};
            nout++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("isr beats", nout, 8);
      check("isr state", pt, 128'h000d0a07_04010e0b_0805020f_0c090603);
      check("isr s1", pt[119:112], 8'h0d);
      check("isr s2", pt[111:104], 8'h0a);
      check("isr s3", pt[103:96], 8'h07);
      check("isr s5", pt[87:80], 8'h01);
      check("isr s15", pt[7:0], 8'h03);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; din_valid = 1'b0; din = '0; sbox_in = '0; out_ready = 1'b0;
      start_p = 1'b0; din_valid_p = 1'b0; din_p = '0; sbox_in_p = '0; out_ready_p = 1'b0;
      imc_col = '0;
      ct_v  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      pt_v  = 128'h00112233445566778899aabbccddeeff;
      key_v = 128'h000102030405060708090a0b0c0d0e0f;
      build_tables();

      imc_tab[0] = '{32'h8e4da1bc, 32'hdb135345};
      imc_tab[1] = '{32'hd5d5d7d6, 32'hd4d4d4d5};
      imc_tab[2] = '{32'h00000000, 32'h00000000};
      imc_tab[3] = '{32'hc6c6c6c6, 32'hc6c6c6c6};

      probes[0]  = '{0,   {1'b0, 1'b0, 4'd0,  1'b0}};
      probes[1]  = '{1,   {1'b1, 1'b0, 4'd0,  1'b0}};
      probes[2]  = '{9,   {1'b1, 1'b1, 4'd10, 1'b0}};
      probes[3]  = '{16,  {1'b1, 1'b1, 4'd10, 1'b0}};
      probes[4]  = '{17,  {1'b1, 1'b0, 4'd10, 1'b0}};
      probes[5]  = '{18,  {1'b1, 1'b0, 4'd9,  1'b0}};
      probes[6]  = '{26,  {1'b1, 1'b0, 4'd9,  1'b0}};
      probes[7]  = '{30,  {1'b1, 1'b0, 4'd9,  1'b0}};
      probes[8]  = '{31,  {1'b1, 1'b0, 4'd8,  1'b0}};
      probes[9]  = '{134, {1'b1, 1'b0, 4'd1,  1'b0}};
      probes[10] = '{135, {1'b1, 1'b0, 4'd0,  1'b0}};
      probes[11] = '{143, {1'b1, 1'b0, 4'd0,  1'b1}};

      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", {busy, done, plain_valid, sb_bypass, key_idx, stateout, plain}, '0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle outputs", {busy, done, plain_valid, sb_bypass, key_idx, stateout, plain}, '0);

      for (int i = 0; i < 4; i++) begin
         imc_col = imc_tab[i].col;
         #1;
         check($sformatf("imc vec %0d", i), imc_res, imc_tab[i].exp);
      end

      run_block("c1", 0, 0, 1'b0, -1, 1'b1, 143, 150);
      do_reset();
      run_block("stall", 3, 2, 1'b0, -1, 1'b0, 146, 155);
      do_reset();
      run_block("abort", 0, 0, 1'b0, 72, 1'b0, 0, 0);
      run_block("after rst", 0, 0, 1'b0, -1, 1'b0, 143, 150);
      do_reset();
      run_block("held start", 0, 0, 1'b1, -1, 1'b0, 143, 150);
      start = 1'b0;
      do_reset();
      run_isr_probe();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
